// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Parametrised register file with a per-entry pending scoreboard and a
//   sequential clear engine that zeroes every entry after reset. Decode
//   reserves a destination (sets its pending bit) at issue. Writeback stores
//   the result and clears the reservation. The hazard unit reads the pending
//   bits to stall dependent instructions.
//
//   Optional feature (compile-time macro REGFILE_BYPASS_EN):
//     When defined, a write in the current cycle is forwarded to any read port
//     that addresses the same entry. The forwarded pending bit reads 0 unless
//     a reserve to that entry happens in the same cycle.
//     When undefined, reads show only the stored array contents and the
//     registered pending bits.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W
//   ZERO_REG 1: entry 0 reads as zero, ignores writes and is never pending
//
// Ports
//   clk                       rising-edge clock
//   reset_n                   asynchronous active-low reset of control state
//   init_busy                 high while the clear engine sweeps the array
//   rg_wrt_en/addr/data       writeback write port
//   rg_rsv_en/addr            reserve port from issue
//   rg_rd_addr1/2             read addresses
//   rg_rd_data1/2             combinational read data
//   rg_pend1/2                pending status of the addressed entries
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              init_busy,
  input  logic              rg_wrt_en,
  input  logic [ADDR_W-1:0] rg_wrt_addr,
  input  logic [DATA_W-1:0] rg_wrt_data,
  input  logic              rg_rsv_en,
  input  logic [ADDR_W-1:0] rg_rsv_addr,
  input  logic [ADDR_W-1:0] rg_rd_addr1,
  input  logic [ADDR_W-1:0] rg_rd_addr2,
  output logic [DATA_W-1:0] rg_rd_data1,
  output logic [DATA_W-1:0] rg_rd_data2,
  output logic              rg_pend1,
  output logic              rg_pend2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              pend;
  } rd_t;

  state_t            state;
  state_t            state_nxt;
  logic              run;
  logic [ADDR_W-1:0] idx;
  logic [DEPTH-1:0]  pending;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_ok;
  logic rsv_ok;
  rd_t  rd1;
  rd_t  rd2;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // FSM: next-state logic
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (idx == LAST_IDX) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    init_busy = (state == ST_INIT);
    run       = (state == ST_RUN);
  end

  // -------------------------------------------------------------------------
  // Clear index: advances once per INIT cycle and wraps to 0 on the last entry
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           idx <= '0;
    else if (state == ST_INIT) idx <= idx + ADDR_W'(1);
  end

  // Accepted write / reserve: only in RUN, and never to a hardwired entry 0.
  always_comb begin
    wr_ok  = run && rg_wrt_en && !((ZERO_REG != 0) && (rg_wrt_addr == '0));
    rsv_ok = run && rg_rsv_en && !((ZERO_REG != 0) && (rg_rsv_addr == '0));
  end

  // -------------------------------------------------------------------------
  // Pending scoreboard. The reserve assignment comes after the clear, so a
  // same-cycle reserve and write to one entry leaves it pending: the reserve
  // marks a newer producer than the value being written back.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      if (wr_ok)  pending[rg_wrt_addr] <= 1'b0;
      if (rsv_ok) pending[rg_rsv_addr] <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset so it can map onto RAM/regfile macros. The
  // INIT sweep zeroes it one entry per cycle after each reset instead.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[idx]         <= '0;
    else if (wr_ok)       mem[rg_wrt_addr] <= rg_wrt_data;
  end

  // -------------------------------------------------------------------------
  // Read ports (combinational). Both outputs are held at 0 during INIT.
  // -------------------------------------------------------------------------
  function automatic rd_t read_port(input logic [ADDR_W-1:0] addr);
    rd_t r;
    r = '0;
    if (run) begin
      r.data = ((ZERO_REG != 0) && (addr == '0)) ? '0 : mem[addr];
      r.pend = pending[addr];
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight writeback. Its reservation is being retired,
      // unless a newer reserve to the same entry lands on this edge.
      if (wr_ok && (rg_wrt_addr == addr)) begin
        r.data = rg_wrt_data;
        if (!(rsv_ok && (rg_rsv_addr == addr))) r.pend = 1'b0;
      end
`endif
    end
    return r;
  endfunction

  always_comb begin
    rd1         = read_port(rg_rd_addr1);
    rd2         = read_port(rg_rd_addr2);
    rg_rd_data1 = rd1.data;
    rg_pend1    = rd1.pend;
    rg_rd_data2 = rd2.data;
    rg_pend2    = rd2.pend;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Scoreboard bench for regfile_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
//
//   Stimulus side: each cycle it drives the inputs and derives the expected
//   read-port values from a behavioural model. The model holds an array of
//   values, an array of pending flags and a count of edges since reset. It
//   pushes the expectation into a queue and then advances the model.
//
//   Monitor side: on every falling edge it pops one expectation and compares
//   it against the DUT outputs.
//
//   Macro REGFILE_BYPASS_EN is honoured in the same way as in the RTL build.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit ZERO   = 1'b1;

  logic              clk;
  logic              reset_n;
  logic              init_busy;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;
  logic              rg_rsv_en;
  logic [ADDR_W-1:0] rg_rsv_addr;
  logic [ADDR_W-1:0] rg_rd_addr1;
  logic [ADDR_W-1:0] rg_rd_addr2;
  logic [DATA_W-1:0] rg_rd_data1;
  logic [DATA_W-1:0] rg_rd_data2;
  logic              rg_pend1;
  logic              rg_pend2;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .init_busy   (init_busy),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .rg_rsv_en   (rg_rsv_en),
    .rg_rsv_addr (rg_rsv_addr),
    .rg_rd_addr1 (rg_rd_addr1),
    .rg_rd_addr2 (rg_rd_addr2),
    .rg_rd_data1 (rg_rd_data1),
    .rg_rd_data2 (rg_rd_data2),
    .rg_pend1    (rg_pend1),
    .rg_pend2    (rg_pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard and counters
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              p1;
    logic              p2;
    logic              busy;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_pend [DEPTH];
  int                m_edges = 0;   // rising edges seen with reset released

  function automatic bit is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO && (a == 0);
  endfunction

  // Expected (data, pend) for one read port in RUN, given this cycle's inputs.
  task automatic model_read(input logic [ADDR_W-1:0] a, input bit we,
                            input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                            input bit rv, input logic [ADDR_W-1:0] ra,
                            output logic [DATA_W-1:0] d, output logic p);
    d = is_zero_reg(a) ? '0 : m_mem[a];
    p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    if (we && !is_zero_reg(wa) && wa == a) begin
      d = wd;
      if (!(rv && !is_zero_reg(ra) && ra == a)) p = 1'b0;
    end
`else
    // Without forwarding the stored value is visible; these inputs are unused.
    if (we && rv && wa == ra && wd == '0) d = d;
`endif
  endtask

  // One clock cycle: drive inputs, push the expectation, advance the model.
  task automatic step(input bit rst_low, input bit we, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input bit rv,
                      input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] a1,
                      input logic [ADDR_W-1:0] a2);
    exp_t e;
    reset_n     = !rst_low;
    rg_wrt_en   = we;
    rg_wrt_addr = wa;
    rg_wrt_data = wd;
    rg_rsv_en   = rv;
    rg_rsv_addr = ra;
    rg_rd_addr1 = a1;
    rg_rd_addr2 = a2;

    if (rst_low || m_edges < DEPTH) begin
      e.d1 = '0; e.d2 = '0; e.p1 = 1'b0; e.p2 = 1'b0; e.busy = 1'b1;
    end else begin
      e.busy = 1'b0;
      model_read(a1, we, wa, wd, rv, ra, e.d1, e.p1);
      model_read(a2, we, wa, wd, rv, ra, e.d2, e.p2);
    end
    sb_q.push_back(e);

    if (rst_low) begin
      // The clear sweep that follows reset leaves every entry at zero.
      m_edges = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_pend[i] = 1'b0;
        m_mem[i]  = '0;
      end
    end else if (m_edges < DEPTH) begin
      m_edges++;
    end else begin
      if (we && !is_zero_reg(wa)) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (rv && !is_zero_reg(ra)) m_pend[ra] = 1'b1;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, a1, a2);
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    // Half the time stay in a small window so collisions are frequent.
    if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 3));
    return ADDR_W'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic rnd_step();
    step(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 1)),
         rnd_addr(), rnd_addr(), rnd_addr());
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("init_busy",   {31'b0, init_busy}, {31'b0, e.busy});
        check("rg_rd_data1", rg_rd_data1,        e.d1);
        check("rg_rd_data2", rg_rd_data2,        e.d2);
        check("rg_pend1",    {31'b0, rg_pend1},  {31'b0, e.p1});
        check("rg_pend2",    {31'b0, rg_pend2},  {31'b0, e.p2});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    rg_wrt_en = 1'b0; rg_wrt_addr = '0; rg_wrt_data = '0;
    rg_rsv_en = 1'b0; rg_rsv_addr = '0;
    rg_rd_addr1 = '0; rg_rd_addr2 = '0;
    @(posedge clk);
    #1;

    // Reset held, then the clear sweep: reads 0 and init_busy high for DEPTH edges.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd2);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd4);
    for (int i = 0; i < DEPTH; i++) idle(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
    for (int i = 0; i < DEPTH; i += 2) idle(ADDR_W'(i), ADDR_W'(i + 1));

    // Reserve 7, observe pending, then write it back.
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, '0, 5'd7, 5'd8);
    idle(5'd7, 5'd8);

    // Same-cycle reserve and write to 9: data lands and the entry stays pending.
    step(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd7);

    // Write to 3 while it is being read (forwarded only with the bypass).
    step(1'b0, 1'b1, 5'd3, 32'h1111_2222, 1'b0, '0, 5'd0, 5'd1);
    step(1'b0, 1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, '0, 5'd1, 5'd3);
    idle(5'd1, 5'd3);

    // Entry 0 ignores writes and reserves.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd9);

    // Reserve on one entry while another is written back.
    step(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd12, 5'd9, 5'd12);
    idle(5'd9, 5'd12);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) rnd_step();

    // Reset mid-RUN, then again at idx=10 of the sweep. Traffic issued while
    // init_busy is high must be ignored, and every entry then reads zero.
    step(1'b1, 1'b1, 5'd5, 32'h5555_5555, 1'b1, 5'd5, 5'd5, 5'd6);
    for (int i = 0; i < 10; i++) rnd_step();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd10, 5'd11);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, ADDR_W'(i), $urandom | 32'h1, 1'b1, ADDR_W'(i), ADDR_W'(i), rnd_addr());
    for (int i = 0; i < DEPTH; i += 2) idle(ADDR_W'(i), ADDR_W'(i + 1));

    // A short random tail after the second sweep.
    for (int i = 0; i < 40; i++) rnd_step();

    @(negedge clk);
    #1;
    check("scoreboard_drained", DATA_W'(sb_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
